// File: rtl/io_pad_arb_pkg.sv
// io_pad_arb_pkg: shared state encoding, width helper and default timing constants for the pad arbiter
package io_pad_arb_pkg;
   typedef enum logic [1:0] {IDLE, SWITCH, OWN} arb_state_t;
   localparam int TURN_CYC_DEF = 2;
   localparam int MAX_HOLD_DEF = 16;
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first requester at or after ptr (wrapping)
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);
   always_comb begin
      valid = |req;
      idx = '0;
      for (int k = N - 1; k >= 0; k--)
         if (req[W'((int'(ptr) + k) % N)]) idx = W'((int'(ptr) + k) % N);
   end
endmodule

// File: rtl/io_pad_arbiter.sv
// io_pad_arbiter: round-robin sharing of a GPIO pad group with a tristated turnaround between owners.
// Define IO_ARB_PREEMPT_EN to preempt an owner that holds the pads for MAX_HOLD cycles while others wait.
module io_pad_arbiter
   import io_pad_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int PAD_W    = 5,
   parameter int TURN_CYC = TURN_CYC_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*PAD_W-1:0] out_i,
   input  logic [NUM_REQ*PAD_W-1:0] oeb_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [PAD_W-1:0]         in_o,
   output logic                     busy_o,
   input  logic [PAD_W-1:0]         io_in,
   output logic [PAD_W-1:0]         io_out,
   output logic [PAD_W-1:0]         io_oeb
);
   localparam int IW = idx_w(NUM_REQ);
   localparam int TW = idx_w(TURN_CYC);
   if (NUM_REQ < 2 || NUM_REQ > 8 || TURN_CYC < 1 || MAX_HOLD < 1) begin : g_bad_cfg
      $error("io_pad_arbiter: unsupported parameter set");
   end
   arb_state_t state;
   logic [IW-1:0] ptr, pend, owner, pick_idx;
   logic [TW-1:0] turn_cnt;
   logic pick_vld, preempt, keep;
   rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
      .req(req_i),
      .ptr(ptr),
      .valid(pick_vld),
      .idx(pick_idx)
   );
   assign in_o = io_in;
`ifdef IO_ARB_PREEMPT_EN
   localparam int HW = idx_w(MAX_HOLD);
   logic [HW-1:0] hold_cnt;
   assign preempt = (hold_cnt == HW'(MAX_HOLD - 1)) && |(req_i & ~(NUM_REQ'(1) << owner));
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) hold_cnt <= '0;
      else hold_cnt <= (state != OWN) ? '0 : (hold_cnt == HW'(MAX_HOLD - 1)) ? hold_cnt : hold_cnt + 1'b1;
`else
   assign preempt = 1'b0;
`endif
   // the owner keeps the pads only for cycles after which it still owns them
   assign keep = (state == OWN) && req_i[owner] && !preempt;
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         ptr <= '0;
         pend <= '0;
         owner <= '0;
         turn_cnt <= '0;
         gnt_o <= '0;
         busy_o <= 1'b0;
         io_out <= '0;
         io_oeb <= '1;
      end else begin
         io_out <= keep ? out_i[int'(owner)*PAD_W +: PAD_W] : '0;
         io_oeb <= keep ? oeb_i[int'(owner)*PAD_W +: PAD_W] : '1;
         case (state)
            IDLE:
               if (pick_vld) begin
                  pend <= pick_idx;
                  turn_cnt <= TW'(TURN_CYC - 1);
                  busy_o <= 1'b1;
                  state <= SWITCH;
               end
            SWITCH:
               if (!req_i[pend]) begin
                  busy_o <= 1'b0;
                  state <= IDLE;
               end else if (turn_cnt == '0) begin
                  owner <= pend;
                  gnt_o <= NUM_REQ'(1) << pend;
                  state <= OWN;
               end else turn_cnt <= turn_cnt - 1'b1;
            OWN:
               if (!keep) begin
                  gnt_o <= '0;
                  ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                  busy_o <= 1'b0;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
